// File: rtl/axi_traffic_gen.sv
// Self-checking AXI4 burst master: writes NUM_BURSTS INCR bursts of a deterministic
// pattern, reads each one straight back, and counts every response/data/rlast mismatch.
module axi_traffic_gen #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BURST_LEN  = 8,
    parameter int                    NUM_BURSTS = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    done,
    output logic                    error,
    output logic [15:0]             err_cnt,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);
    localparam int                    BYTES      = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(BURST_LEN * BYTES);
    localparam logic [8:0]            LAST_BEAT  = 9'(BURST_LEN - 1);
    localparam logic [31:0]           LAST_BURST = 32'(NUM_BURSTS - 1);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [31:0]           burst;
    logic [8:0]            beat;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           word;
    logic [DATA_WIDTH-1:0] pattern;
    logic                  go, beat_last, burst_last;
    logic [1:0]            n_fail;
    logic [16:0]           cnt_sum;

    assign word       = {burst[15:0], beat[7:0], ~beat[7:0]};
    assign pattern    = {(DATA_WIDTH/32){word}};
    assign beat_last  = (beat == LAST_BEAT);
    assign burst_last = (burst == LAST_BURST);
    assign go         = start && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: if (start)               state_nxt = S_AW;
            S_AW:           if (awready)             state_nxt = S_W;
            S_W:            if (wready && beat_last) state_nxt = S_B;
            S_B:            if (bvalid)              state_nxt = S_AR;
            S_AR:           if (arready)             state_nxt = S_R;
            S_R:            if (rvalid && beat_last) state_nxt = burst_last ? S_DONE : S_AW;
            default:                                 state_nxt = S_IDLE;
        endcase
    end

    // Several failures on one R beat are all counted; max three per cycle.
    always_comb begin
        n_fail = '0;
        if (state == S_B && bvalid && bresp != 2'b00)
            n_fail = 2'd1;
        if (state == S_R && rvalid)
            n_fail = 2'(rresp != 2'b00) + 2'(rdata != pattern) + 2'(rlast != beat_last);
    end

    assign cnt_sum = {1'b0, err_cnt} + 17'(n_fail);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst   <= '0;
            beat    <= '0;
            addr    <= '0;
            err_cnt <= '0;
            error   <= 1'b0;
        end else if (go) begin
            burst   <= '0;
            beat    <= '0;
            addr    <= BASE_ADDR;
            err_cnt <= '0;
            error   <= 1'b0;
        end else begin
            if ((state == S_W && wready) || (state == S_R && rvalid))
                beat <= beat_last ? '0 : beat + 9'd1;
            if (state == S_R && rvalid && beat_last && !burst_last) begin
                burst <= burst + 32'd1;
                addr  <= addr + STRIDE;
            end
            if (n_fail != 2'd0) begin
                err_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
                error   <= 1'b1;
            end
        end
    end

    // Write and read of one burst share the same address register.
    assign awaddr  = addr;
    assign araddr  = addr;
    assign awlen   = 8'(BURST_LEN - 1);
    assign arlen   = 8'(BURST_LEN - 1);
    assign awvalid = (state == S_AW);
    assign wvalid  = (state == S_W);
    assign wdata   = (state == S_W) ? pattern : '0;
    assign wstrb   = '1;
    assign wlast   = (state == S_W) && beat_last;
    assign bready  = (state == S_B);
    assign arvalid = (state == S_AR);
    assign rready  = (state == S_R);
    assign done    = (state == S_DONE);
endmodule

// File: doc/axi_traffic_gen.md
Name:
axi_traffic_gen

Overview:
Parametrised, self-checking AXI4 burst master used as traffic source and checker inside axi_top, in place of the fixed-pattern master. On start it runs NUM_BURSTS write bursts, reading back each one immediately after it is written, compares the data against a deterministic pattern, and reports a sticky error flag and a saturating mismatch count for the testbench to poll.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width; one of 32/64/128; every beat is full-width
BURST_LEN, 8, beats per burst, 1..256; AxLEN = BURST_LEN-1
NUM_BURSTS, 16, bursts per run, >=1
BASE_ADDR, 0, address of burst 0; aligned to DATA_WIDTH/8

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; starts a run when idle or done
done  output  1  high from run completion until the next start
error  output  1  sticky; set on any check failure, cleared by an accepted start
err_cnt  output  16  count of failed checks, saturates at 16'hFFFF
awaddr  output  ADDR_WIDTH  write burst address
awlen  output  8  BURST_LEN-1
awvalid  output  1  AW valid
awready  input  1  AW ready
wdata  output  DATA_WIDTH  write beat data
wstrb  output  DATA_WIDTH/8  all ones
wlast  output  1  high on beat BURST_LEN-1
wvalid  output  1  W valid
wready  input  1  W ready
bresp  input  2  write response
bvalid  input  1  B valid
bready  output  1  B ready
araddr  output  ADDR_WIDTH  read burst address
arlen  output  8  BURST_LEN-1
arvalid  output  1  AR valid
arready  input  1  AR ready
rdata  input  DATA_WIDTH  read beat data
rresp  input  2  read response
rlast  input  1  last read beat
rvalid  input  1  R valid
rready  output  1  R ready

Behaviour:
- Decided: one clock, clk; reset rst_n is asynchronous, active-low. Reset forces state IDLE; all valid/ready outputs, done, error, wlast and every counter go to 0; addr/data outputs go to 0. Reset mid-burst abandons the transfer immediately.
- Fixed burst type: INCR, size log2(DATA_WIDTH/8). Burst n address A(n) = BASE_ADDR + n*BURST_LEN*(DATA_WIDTH/8), truncated to ADDR_WIDTH. Beat b address = A(n)+b*(DATA_WIDTH/8).
- Pattern for beat b of burst n: 32-bit word {n[15:0], b[7:0], ~b[7:0]}, replicated to DATA_WIDTH.
- FSM: IDLE -start-> AW -> W -> B -> AR -> R -> (n==NUM_BURSTS-1 ? DONE : AW with n+1). DONE -start-> AW. start is ignored in every other state; an accepted start clears n, err_cnt and error. States advance only on handshakes; there are no idle cycles between states.
- AW/AR: valid is asserted on state entry and held, with addr/len stable, until ready (ready may already be high: 1-cycle handshake). W: wvalid is held high across all beats; a beat advances on wvalid&wready; wlast is high only on beat BURST_LEN-1. Valid never depends combinationally on ready. AW completes before the first W beat; the next AR is issued only after B.
- bready is high only in B. rready is high for the whole of R. Each beat compares rdata against the pattern.
- Each of these counts as one failed check (err_cnt +1, sets error): bresp!=0; rresp!=0 on a beat; rdata mismatch on a beat; rlast value differing from (beat==BURST_LEN-1). Several failures on the same beat add the count of failures, saturating. R ends on the BURST_LEN-th beat whatever rlast is.
- done is set in the cycle after the last R handshake of burst NUM_BURSTS-1.

Test Plan:
- Default params, ideal slave (ready always high, OKAY) -> 16 bursts of 8 beats; done after the final R; error=0, err_cnt=0; awaddr sequence 0x0,0x20,...,0x1E0.
- Random ready/valid backpressure on all channels -> identical address/data sequence; valids and payloads held stable while stalled; error=0.
- Slave corrupts rdata bit 0 on beat 3 of burst 5 -> err_cnt=1, error=1 from that cycle onward; run still completes with done=1.
- bresp=SLVERR on burst 2 plus rlast asserted on beat 6 of burst 4 -> err_cnt=2.
- DATA_WIDTH=64, BURST_LEN=1, NUM_BURSTS=3 -> awlen=0, wlast on every beat, addresses 0x0,0x8,0x10.
- rst_n low mid-W of burst 7, then start -> all valids 0 in the reset cycle; new run restarts at BASE_ADDR with err_cnt=0.
